// File: rtl/formula_1_inv_pipe.sv
// Pipelined sum of squares: res = x*x + y*y + z*z, one argument set per clock.
// Each operand goes through a W-stage shift-add squarer. A single summation stage follows it.

module formula_1_inv_sq #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic [W-1:0]   en,
    input  logic [W-1:0]   op,
    output logic [2*W-1:0] sq
);

    localparam int unsigned SW = 2 * W;

    // Operand copies travel alongside the partial products. The last stage needs no copy.
    logic [W-1:0]  op_r  [W-1];
    logic [SW-1:0] acc_r [W];

    // Stage 0 seeds the accumulator with multiplier bit 0.
    always_ff @(posedge clk) begin
        if (en[0]) begin
            acc_r[0] <= op[0] ? SW'(op) : SW'(0);
            op_r[0]  <= op;
        end
    end

    for (genvar i = 1; i < W; i++) begin : g_stage
        // Stage i adds the partial product for multiplier bit i.
        always_ff @(posedge clk) begin
            if (en[i]) begin
                acc_r[i] <= acc_r[i-1] + (op_r[i-1][i] ? (SW'(op_r[i-1]) << i) : SW'(0));
            end
        end

        if (i < W - 1) begin : g_op
            always_ff @(posedge clk) begin
                if (en[i]) begin
                    op_r[i] <= op_r[i-1];
                end
            end
        end
    end

    assign sq = acc_r[W-1];

endmodule

module formula_1_inv_pipe #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic [W-1:0]   z,
    output logic           res_vld,
    output logic [2*W+1:0] res
);

    localparam int unsigned SW = 2 * W;
    localparam int unsigned RW = 2 * W + 2;

    logic [W-1:0]  vld;
    logic [W-1:0]  stage_en;
    logic [SW-1:0] sq_x;
    logic [SW-1:0] sq_y;
    logic [SW-1:0] sq_z;

    // One valid chain serves all three squarers. Each stage loads only on its incoming valid.
    assign stage_en = {vld[W-2:0], arg_vld};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld <= stage_en;
        end
    end

    formula_1_inv_sq #(.W(W)) u_sq_x (
        .clk (clk),
        .en  (stage_en),
        .op  (x),
        .sq  (sq_x)
    );

    formula_1_inv_sq #(.W(W)) u_sq_y (
        .clk (clk),
        .en  (stage_en),
        .op  (y),
        .sq  (sq_y)
    );

    formula_1_inv_sq #(.W(W)) u_sq_z (
        .clk (clk),
        .en  (stage_en),
        .op  (z),
        .sq  (sq_z)
    );

    // The sum stage holds the last result between valid sets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld <= 1'b0;
            res     <= '0;
        end else begin
            res_vld <= vld[W-1];
            if (vld[W-1]) begin
                res <= RW'(sq_x) + RW'(sq_y) + RW'(sq_z);
            end
        end
    end

endmodule

// File: tb/tb_formula_1_inv_pipe.sv
// Directed bench for formula_1_inv_pipe.
// A 17-deep history model predicts res_vld and res every cycle.

module tb_formula_1_inv_pipe;

    logic        clk;
    logic        rst;
    logic        arg_vld;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        res_vld;
    logic [33:0] res;

    int n_checks;
    int n_errors;

    logic        hist_v [0:16];
    logic [33:0] hist_r [0:16];
    logic [33:0] exp_res;
    logic        seen_vld;

    formula_1_inv_pipe #(.W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld),
        .x       (x),
        .y       (y),
        .z       (z),
        .res_vld (res_vld),
        .res     (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k <= 16; k++) begin
            hist_v[k] = 1'b0;
            hist_r[k] = '0;
        end
        exp_res = '0;
    endtask

    // Compare outputs against the set driven 17 cycles ago, then drive the next cycle.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c);
        @(negedge clk);
        seen_vld = res_vld;
        if (hist_v[16]) exp_res = hist_r[16];
        chk("res_vld", {33'b0, res_vld}, {33'b0, hist_v[16]});
        chk("res", res, exp_res);
        for (int k = 16; k > 0; k--) begin
            hist_v[k] = hist_v[k-1];
            hist_r[k] = hist_r[k-1];
        end
        hist_v[0] = v;
        hist_r[0] = 34'(a) * 34'(a) + 34'(b) * 34'(b) + 34'(c) * 34'(c);
        arg_vld = v;
        x = a;
        y = b;
        z = c;
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        int pulses;
        int at;
        int cnt;
        int first;
        int last;
        logic [15:0] ra;

        n_checks = 0;
        n_errors = 0;
        seen_vld = 1'b0;
        clear_model();
        rst = 1'b1;
        arg_vld = 1'b0;
        x = '0;
        y = '0;
        z = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", {33'b0, res_vld}, 34'd0);
        chk("reset_res", res, 34'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single set 3,4,12 gives exactly one pulse 17 cycles later.
        step(1'b1, 16'd3, 16'd4, 16'd12);
        pulses = 0;
        at = 0;
        for (int k = 1; k <= 25; k++) begin
            idle();
            if (seen_vld) begin
                pulses++;
                at = k;
            end
        end
        chk("single_pulses", 34'(pulses), 34'd1);
        chk("single_latency", 34'(at), 34'd17);
        chk("single_hold", res, 34'd169);

        // Maximum operands, then all zeros, back to back.
        step(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step(1'b1, 16'h0000, 16'h0000, 16'h0000);
        repeat (15) idle();
        idle();
        chk("max_vld", {33'b0, seen_vld}, 34'd1);
        chk("max_res", res, 34'h2_FFFA_0003);
        idle();
        chk("zero_vld", {33'b0, seen_vld}, 34'd1);
        chk("zero_res", res, 34'd0);
        repeat (5) idle();

        // 20 back-to-back sets i, 2i, 3i give res = 14*i*i.
        cnt = 0;
        first = -1;
        last = -1;
        for (int k = 0; k < 45; k++) begin
            if (k < 20) step(1'b1, 16'(k), 16'(2 * k), 16'(3 * k));
            else idle();
            if (seen_vld) begin
                chk("b2b_res", res, 34'(14 * cnt * cnt));
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
        end
        chk("b2b_count", 34'(cnt), 34'd20);
        chk("b2b_contiguous", 34'(last - first), 34'd19);
        chk("b2b_first", 34'(first), 34'd17);

        // Gapped pattern 1,0,0,1,1,0,1 with random roots.
        pulses = 0;
        for (int k = 0; k < 27; k++) begin
            if (k < 7) begin
                ra = 16'($urandom);
                step((k == 0 || k == 3 || k == 4 || k == 6), ra, 16'($urandom), 16'($urandom));
            end else begin
                idle();
            end
            if (seen_vld) pulses++;
        end
        chk("gap_pulses", 34'(pulses), 34'd4);

        // Asynchronous reset with 8 sets in flight.
        for (int k = 0; k < 8; k++) step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
        @(posedge clk);
        #2;
        rst = 1'b0;
        arg_vld = 1'b0;
        #1;
        chk("rst_async_vld", {33'b0, res_vld}, 34'd0);
        chk("rst_async_res", res, 34'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        step(1'b1, 16'd5, 16'd6, 16'd7);
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            idle();
            if (seen_vld) pulses++;
        end
        chk("post_rst_pulses", 34'(pulses), 34'd1);
        chk("post_rst_res", res, 34'd110);

        // Random sets with varying valid density.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) < (k % 100)), 16'($urandom), 16'($urandom),
                 16'($urandom));
        end
        repeat (20) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
